// File: rtl/unary_add_digit_if.sv
// ---------------------------------------------------------------------------
// unary_add_digit_if
//   Bundles the control, unary data and status signals of one unary adder
//   digit so that chained digits and their drivers connect through one port.
//
//   Parameters
//     NCH : number of unary input lanes
//     CW  : width of the residual count
//
//   Signals
//     en       clock enable for the digit
//     clr      synchronous clear (acts only while en=1)
//     mode     0 = accumulate, 1 = emit
//     din      NCH unary input pulses, one bit per lane
//     cin      carry in from the lower digit (only with UNARY_ADD_CIN_EN)
//     dout     serial unary output pulse train
//     carry    one-cycle wrap pulse
//     done     one-cycle end-of-emit pulse
//     count_o  residual count, always below the modulus
//
//   Modports
//     master : drives en/clr/mode/din/cin, observes the outputs
//     slave  : the digit itself
//
//   Optional feature macro: UNARY_ADD_CIN_EN adds the cin signal.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

interface unary_add_digit_if #(
  parameter int NCH = 2,
  parameter int CW  = 4
);
  logic           en;
  logic           clr;
  logic           mode;
  logic [NCH-1:0] din;
`ifdef UNARY_ADD_CIN_EN
  logic           cin;
`endif
  logic           dout;
  logic           carry;
  logic           done;
  logic [CW-1:0]  count_o;

  modport master (
    output en,
    output clr,
    output mode,
    output din,
`ifdef UNARY_ADD_CIN_EN
    output cin,
`endif
    input  dout,
    input  carry,
    input  done,
    input  count_o
  );

  modport slave (
    input  en,
    input  clr,
    input  mode,
    input  din,
`ifdef UNARY_ADD_CIN_EN
    input  cin,
`endif
    output dout,
    output carry,
    output done,
    output count_o
  );
endinterface

// File: rtl/unary_add_digit.sv
// ---------------------------------------------------------------------------
// unary_add_digit
//   One radix-MOD digit of a unary (pulse-count) adder.
//   Accumulate phase (mode=0): every enabled cycle the number of set lanes
//   of din (plus cin when enabled) is added to the residual count modulo MOD;
//   a wrap produces a one-cycle carry pulse, which feeds cin of the next
//   digit up the chain.
//   Emit phase (mode=1): the residual count is replayed on dout as a run of
//   consecutive '1' cycles, one per unit, followed by a single done pulse,
//   after which the digit parks in HOLD until mode returns to 0.
//
//   The lane count NCH must stay below the modulus (which is at least 2),
//   and the count width CW must hold the modulus plus NCH plus one.
//
//   Clocking is on the rising edge of clk with an asynchronous active-low
//   rst_n; all control, data and status travel on the unary_add_digit_if
//   slave modport, and every output is a flop.
//
//   With UNARY_ADD_CIN_EN the cin input adds one unit in the accumulate
//   phase; without it the increment is the popcount of din only.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module unary_add_digit #(
  parameter int NCH = 2,
  parameter int MOD = 10,
  parameter int CW  = 4
) (
  input logic              clk,
  input logic              rst_n,
  unary_add_digit_if.slave bus
);

  localparam logic [1:0] ST_ACC  = 2'd0;
  localparam logic [1:0] ST_EMIT = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;

  localparam logic [CW-1:0] MOD_C  = CW'(MOD);
  localparam logic [CW-1:0] ZERO_C = {CW{1'b0}};
  localparam logic [CW-1:0] ONE_C  = {{(CW-1){1'b0}}, 1'b1};

  // Number of set bits on the lane vector, as a count-width value.
  function automatic logic [CW-1:0] popcount(input logic [NCH-1:0] v);
    logic [CW-1:0] n;
    n = ZERO_C;
    for (int i = 0; i < NCH; i++) begin
      n = n + {{(CW-1){1'b0}}, v[i]};
    end
    return n;
  endfunction

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic          dout_q,  dout_d;
  logic          carry_q, carry_d;
  logic          done_q,  done_d;

  logic [CW-1:0] inc_s;
  logic [CW-1:0] sum_s;

  // Increment and unwrapped sum for the accumulate phase; CW is sized so the
  // sum cannot overflow, and NCH+1 <= MOD guarantees at most one wrap.
  always_comb begin
`ifdef UNARY_ADD_CIN_EN
    inc_s = popcount(bus.din) + {{(CW-1){1'b0}}, bus.cin};
`else
    inc_s = popcount(bus.din);
`endif
    sum_s = count_q + inc_s;
  end

  // Next-state logic: enable gates everything, clear beats the FSM, and the
  // pulse outputs default low so they last exactly one enabled cycle.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    dout_d  = dout_q;
    carry_d = 1'b0;
    done_d  = 1'b0;

    if (!bus.en) begin
      // Frozen: state, count and dout keep their values; pulses drop.
      state_d = state_q;
      count_d = count_q;
      dout_d  = dout_q;
    end else if (bus.clr) begin
      state_d = ST_ACC;
      count_d = ZERO_C;
      dout_d  = 1'b0;
    end else begin
      case (state_q)
        ST_ACC: begin
          dout_d = 1'b0;
          if (bus.mode) begin
            // Switching to emit: this cycle's din/cin are dropped.
            state_d = ST_EMIT;
          end else if (sum_s >= MOD_C) begin
            count_d = sum_s - MOD_C;
            carry_d = 1'b1;
          end else begin
            count_d = sum_s;
          end
        end
        ST_EMIT: begin
          if (!bus.mode) begin
            // Abort keeps the residual count for further accumulation.
            state_d = ST_ACC;
            dout_d  = 1'b0;
          end else if (count_q != ZERO_C) begin
            dout_d  = 1'b1;
            count_d = count_q - ONE_C;
          end else begin
            dout_d  = 1'b0;
            done_d  = 1'b1;
            state_d = ST_HOLD;
          end
        end
        ST_HOLD: begin
          dout_d  = 1'b0;
          count_d = ZERO_C;
          if (!bus.mode) begin
            state_d = ST_ACC;
          end else begin
            state_d = ST_HOLD;
          end
        end
        default: begin
          state_d = ST_ACC;
          count_d = ZERO_C;
          dout_d  = 1'b0;
        end
      endcase
    end
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_ACC;
      count_q <= ZERO_C;
      dout_q  <= 1'b0;
      carry_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      dout_q  <= dout_d;
      carry_q <= carry_d;
      done_q  <= done_d;
    end
  end

  assign bus.dout    = dout_q;
  assign bus.carry   = carry_q;
  assign bus.done    = done_q;
  assign bus.count_o = count_q;

endmodule

// File: tb/tb_unary_add_digit.sv
// ---------------------------------------------------------------------------
// tb_unary_add_digit
//   Self-checking bench for unary_add_digit (NCH=2, MOD=10, CW=4). Each test
//   task builds a list of per-cycle stimulus with the expected registered
//   outputs, pushes the expectation into a scoreboard queue as the stimulus
//   is applied, and pops/compares it after the clock edge.
//   Observed vector layout: {count_o[3:0], carry, dout, done}.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_unary_add_digit;
  localparam int NCH = 2;
  localparam int MOD = 10;
  localparam int CW  = 4;
`ifdef UNARY_ADD_CIN_EN
  localparam int CIN_W = 1;
`else
  localparam int CIN_W = 0;
`endif

  typedef struct packed {
    logic       en;
    logic       clr;
    logic       mode;
    logic [1:0] din;
    logic       cin;
    logic [6:0] exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  int   checks   = 0;
  int   failures = 0;
  logic [6:0] sb_q[$];

  always #5 clk = ~clk;

  unary_add_digit_if #(.NCH(NCH), .CW(CW)) bus ();

  unary_add_digit #(.NCH(NCH), .MOD(MOD), .CW(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  function automatic logic [6:0] pack(input logic [3:0] c, input logic cy, input logic d, input logic dn);
    return {c, cy, d, dn};
  endfunction

  function automatic vec_t mk(input logic en, input logic clr, input logic mode, input logic [1:0] din,
                              input logic cin, input logic [3:0] c, input logic cy, input logic d, input logic dn);
    vec_t v;
    v.en = en; v.clr = clr; v.mode = mode; v.din = din; v.cin = cin;
    v.exp = pack(c, cy, d, dn);
    return v;
  endfunction

  function automatic logic [6:0] obs();
    return {bus.count_o, bus.carry, bus.dout, bus.done};
  endfunction

  task automatic drive(input logic en, input logic clr, input logic mode, input logic [1:0] din, input logic cin);
    bus.en   = en;
    bus.clr  = clr;
    bus.mode = mode;
    bus.din  = din;
`ifdef UNARY_ADD_CIN_EN
    bus.cin  = cin;
`else
    if (cin === 1'bx) bus.din = din;
`endif
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [6:0] e;
    drive(1'b0, 1'b0, 1'b0, 2'b00, 1'b0);
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #2;
    sb_q.push_back(pack(4'd0, 1'b0, 1'b0, 1'b0));
    e = sb_q.pop_front();
    checks++;
    if (obs() !== e) begin
      failures++;
      $display("FAIL reset: got %b expected %b", obs(), e);
    end
    step();
    rst_n = 1'b1;
    drive(1'b1, 1'b0, 1'b0, 2'b00, 1'b0);
    step();
  endtask

  task automatic test_accumulate();
    vec_t v[$];
    logic [6:0] e;
    v.push_back(mk(1'b1, 1'b0, 1'b0, 2'b11, 1'b0, 4'd2, 1'b0, 1'b0, 1'b0));
    v.push_back(mk(1'b1, 1'b0, 1'b0, 2'b11, 1'b0, 4'd4, 1'b0, 1'b0, 1'b0));
    v.push_back(mk(1'b1, 1'b0, 1'b0, 2'b11, 1'b0, 4'd6, 1'b0, 1'b0, 1'b0));
    v.push_back(mk(1'b1, 1'b0, 1'b0, 2'b11, 1'b0, 4'd8, 1'b0, 1'b0, 1'b0));
    v.push_back(mk(1'b1, 1'b0, 1'b0, 2'b01, 1'b0, 4'd9, 1'b0, 1'b0, 1'b0));
    foreach (v[i]) begin
      drive(v[i].en, v[i].clr, v[i].mode, v[i].din, v[i].cin);
      sb_q.push_back(v[i].exp);
      step();
      e = sb_q.pop_front();
      checks++;
      if (obs() !== e) begin
        failures++;
        $display("FAIL accumulate[%0d]: got %b expected %b", i, obs(), e);
      end
    end
  endtask

  task automatic test_wrap();
    vec_t v[$];
    logic [6:0] e;
    logic [3:0] w;
    w = 4'(9 + 2 + CIN_W - MOD);
    v.push_back(mk(1'b1, 1'b0, 1'b0, 2'b11, 1'b1, w, 1'b1, 1'b0, 1'b0));
    v.push_back(mk(1'b1, 1'b0, 1'b0, 2'b00, 1'b0, w, 1'b0, 1'b0, 1'b0));
    v.push_back(mk(1'b1, 1'b0, 1'b0, 2'b00, 1'b0, w, 1'b0, 1'b0, 1'b0));
    foreach (v[i]) begin
      drive(v[i].en, v[i].clr, v[i].mode, v[i].din, v[i].cin);
      sb_q.push_back(v[i].exp);
      step();
      e = sb_q.pop_front();
      checks++;
      if (obs() !== e) begin
        failures++;
        $display("FAIL wrap[%0d]: got %b expected %b", i, obs(), e);
      end
    end
  endtask

  task automatic test_emit();
    vec_t v[$];
    logic [6:0] e;
    v.push_back(mk(1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0));
    v.push_back(mk(1'b1, 1'b0, 1'b0, 2'b11, 1'b0, 4'd2, 1'b0, 1'b0, 1'b0));
    v.push_back(mk(1'b1, 1'b0, 1'b0, 2'b01, 1'b0, 4'd3, 1'b0, 1'b0, 1'b0));
    v.push_back(mk(1'b1, 1'b0, 1'b1, 2'b11, 1'b1, 4'd3, 1'b0, 1'b0, 1'b0));
    v.push_back(mk(1'b1, 1'b0, 1'b1, 2'b00, 1'b0, 4'd2, 1'b0, 1'b1, 1'b0));
    v.push_back(mk(1'b1, 1'b0, 1'b1, 2'b00, 1'b0, 4'd1, 1'b0, 1'b1, 1'b0));
    v.push_back(mk(1'b1, 1'b0, 1'b1, 2'b00, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0));
    v.push_back(mk(1'b1, 1'b0, 1'b1, 2'b00, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1));
    v.push_back(mk(1'b1, 1'b0, 1'b1, 2'b11, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0));
    v.push_back(mk(1'b1, 1'b0, 1'b0, 2'b11, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0));
    v.push_back(mk(1'b1, 1'b0, 1'b0, 2'b11, 1'b0, 4'd2, 1'b0, 1'b0, 1'b0));
    foreach (v[i]) begin
      drive(v[i].en, v[i].clr, v[i].mode, v[i].din, v[i].cin);
      sb_q.push_back(v[i].exp);
      step();
      e = sb_q.pop_front();
      checks++;
      if (obs() !== e) begin
        failures++;
        $display("FAIL emit[%0d]: got %b expected %b", i, obs(), e);
      end
    end
  endtask

  task automatic test_emit_zero();
    vec_t v[$];
    logic [6:0] e;
    v.push_back(mk(1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0));
    v.push_back(mk(1'b1, 1'b0, 1'b1, 2'b00, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0));
    v.push_back(mk(1'b1, 1'b0, 1'b1, 2'b00, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1));
    v.push_back(mk(1'b1, 1'b0, 1'b1, 2'b00, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0));
    v.push_back(mk(1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0));
    foreach (v[i]) begin
      drive(v[i].en, v[i].clr, v[i].mode, v[i].din, v[i].cin);
      sb_q.push_back(v[i].exp);
      step();
      e = sb_q.pop_front();
      checks++;
      if (obs() !== e) begin
        failures++;
        $display("FAIL emit_zero[%0d]: got %b expected %b", i, obs(), e);
      end
    end
  endtask

  task automatic test_abort_en();
    vec_t v[$];
    logic [6:0] e;
    v.push_back(mk(1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0));
    v.push_back(mk(1'b1, 1'b0, 1'b0, 2'b11, 1'b0, 4'd2, 1'b0, 1'b0, 1'b0));
    v.push_back(mk(1'b1, 1'b0, 1'b0, 2'b11, 1'b0, 4'd4, 1'b0, 1'b0, 1'b0));
    v.push_back(mk(1'b1, 1'b0, 1'b0, 2'b11, 1'b0, 4'd6, 1'b0, 1'b0, 1'b0));
    v.push_back(mk(1'b1, 1'b0, 1'b1, 2'b00, 1'b0, 4'd6, 1'b0, 1'b0, 1'b0));
    v.push_back(mk(1'b1, 1'b0, 1'b1, 2'b00, 1'b0, 4'd5, 1'b0, 1'b1, 1'b0));
    v.push_back(mk(1'b1, 1'b0, 1'b1, 2'b00, 1'b0, 4'd4, 1'b0, 1'b1, 1'b0));
    v.push_back(mk(1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 4'd4, 1'b0, 1'b0, 1'b0));
    v.push_back(mk(1'b0, 1'b0, 1'b0, 2'b11, 1'b1, 4'd4, 1'b0, 1'b0, 1'b0));
    v.push_back(mk(1'b0, 1'b0, 1'b0, 2'b11, 1'b1, 4'd4, 1'b0, 1'b0, 1'b0));
    v.push_back(mk(1'b0, 1'b0, 1'b0, 2'b11, 1'b1, 4'd4, 1'b0, 1'b0, 1'b0));
    v.push_back(mk(1'b1, 1'b0, 1'b1, 2'b00, 1'b0, 4'd4, 1'b0, 1'b0, 1'b0));
    v.push_back(mk(1'b1, 1'b0, 1'b1, 2'b00, 1'b0, 4'd3, 1'b0, 1'b1, 1'b0));
    v.push_back(mk(1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 4'd3, 1'b0, 1'b1, 1'b0));
    v.push_back(mk(1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 4'd3, 1'b0, 1'b1, 1'b0));
    v.push_back(mk(1'b1, 1'b0, 1'b1, 2'b00, 1'b0, 4'd2, 1'b0, 1'b1, 1'b0));
    v.push_back(mk(1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 4'd2, 1'b0, 1'b0, 1'b0));
    foreach (v[i]) begin
      drive(v[i].en, v[i].clr, v[i].mode, v[i].din, v[i].cin);
      sb_q.push_back(v[i].exp);
      step();
      e = sb_q.pop_front();
      checks++;
      if (obs() !== e) begin
        failures++;
        $display("FAIL abort_en[%0d]: got %b expected %b", i, obs(), e);
      end
    end
  endtask

  task automatic test_clr();
    vec_t v[$];
    logic [6:0] e;
    // count starts at 2 from the previous task
    v.push_back(mk(1'b1, 1'b0, 1'b0, 2'b11, 1'b0, 4'd4, 1'b0, 1'b0, 1'b0));
    v.push_back(mk(1'b1, 1'b0, 1'b0, 2'b11, 1'b0, 4'd6, 1'b0, 1'b0, 1'b0));
    v.push_back(mk(1'b1, 1'b0, 1'b0, 2'b11, 1'b0, 4'd8, 1'b0, 1'b0, 1'b0));
    v.push_back(mk(1'b1, 1'b1, 1'b1, 2'b11, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0));
    v.push_back(mk(1'b1, 1'b0, 1'b0, 2'b01, 1'b0, 4'd1, 1'b0, 1'b0, 1'b0));
    v.push_back(mk(1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 4'd1, 1'b0, 1'b0, 1'b0));
    v.push_back(mk(1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0));
    foreach (v[i]) begin
      drive(v[i].en, v[i].clr, v[i].mode, v[i].din, v[i].cin);
      sb_q.push_back(v[i].exp);
      step();
      e = sb_q.pop_front();
      checks++;
      if (obs() !== e) begin
        failures++;
        $display("FAIL clr[%0d]: got %b expected %b", i, obs(), e);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [6:0] e;
    int cnt;
    int s;
    logic cy;
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 1'b0, 1'b0, 2'b11, 1'b1);
      s = cnt + 2 + CIN_W;
      if (s >= MOD) begin
        cnt = s - MOD;
        cy  = 1'b1;
      end else begin
        cnt = s;
        cy  = 1'b0;
      end
      sb_q.push_back(pack(4'(cnt), cy, 1'b0, 1'b0));
      step();
      e = sb_q.pop_front();
      checks++;
      if (obs() !== e) begin
        failures++;
        $display("FAIL back_to_back[%0d]: got %b expected %b", i, obs(), e);
      end
    end
  endtask

  task automatic test_reset_mid_emit();
    vec_t v[$];
    logic [6:0] e;
    v.push_back(mk(1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0));
    v.push_back(mk(1'b1, 1'b0, 1'b0, 2'b11, 1'b0, 4'd2, 1'b0, 1'b0, 1'b0));
    v.push_back(mk(1'b1, 1'b0, 1'b0, 2'b11, 1'b0, 4'd4, 1'b0, 1'b0, 1'b0));
    v.push_back(mk(1'b1, 1'b0, 1'b0, 2'b01, 1'b0, 4'd5, 1'b0, 1'b0, 1'b0));
    v.push_back(mk(1'b1, 1'b0, 1'b1, 2'b00, 1'b0, 4'd5, 1'b0, 1'b0, 1'b0));
    v.push_back(mk(1'b1, 1'b0, 1'b1, 2'b00, 1'b0, 4'd4, 1'b0, 1'b1, 1'b0));
    foreach (v[i]) begin
      drive(v[i].en, v[i].clr, v[i].mode, v[i].din, v[i].cin);
      sb_q.push_back(v[i].exp);
      step();
      e = sb_q.pop_front();
      checks++;
      if (obs() !== e) begin
        failures++;
        $display("FAIL reset_mid_emit_pre[%0d]: got %b expected %b", i, obs(), e);
      end
    end
    // Asynchronous reset between edges: outputs must clear without a clock.
    #1 rst_n = 1'b0;
    #1;
    sb_q.push_back(pack(4'd0, 1'b0, 1'b0, 1'b0));
    e = sb_q.pop_front();
    checks++;
    if (obs() !== e) begin
      failures++;
      $display("FAIL reset_mid_emit_async: got %b expected %b", obs(), e);
    end
    step();
    rst_n = 1'b1;
    // Back in ACC after reset: mode=0 accumulates, no stray done/carry.
    drive(1'b1, 1'b0, 1'b0, 2'b01, 1'b0);
    sb_q.push_back(pack(4'd1, 1'b0, 1'b0, 1'b0));
    step();
    e = sb_q.pop_front();
    checks++;
    if (obs() !== e) begin
      failures++;
      $display("FAIL reset_mid_emit_after: got %b expected %b", obs(), e);
    end
  endtask

  initial begin
    test_reset();
    test_accumulate();
    test_wrap();
    test_emit();
    test_emit_zero();
    test_abort_en();
    test_clr();
    test_back_to_back();
    test_reset_mid_emit();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
